// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the mips core front end: instruction opcode
//   constants, the fetch-stage state enumeration and the default reset PC.
//   No ports; imported with "import mips_pkg::*;".
package mips_pkg;

  // Primary opcode field values (Instr[31:26]) decoded by the ControlUnit.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Address of the first instruction fetched after reset (word aligned).
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch stage sequencing.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// pc_next
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     pcPlus4_i     address of the current instruction + 4
//     imm_i         16-bit branch offset field of the current instruction
//     taken_i       Branch & Zero for the current instruction
//     redirect_i    abandon the stream and continue at redirectPc_i
//     redirectPc_i  redirect target; the two low bits are cleared
//     nextPc_o      selected next fetch address
module pc_next (
  input  logic [31:0] pcPlus4_i,
  input  logic [15:0] imm_i,
  input  logic        taken_i,
  input  logic        redirect_i,
  input  logic [31:0] redirectPc_i,
  output logic [31:0] nextPc_o
);

  logic [31:0] branchTarget;

  // Word offset sign-extended and scaled by 4; the add wraps modulo 2^32.
  assign branchTarget = pcPlus4_i + {{14{imm_i[15]}}, imm_i, 2'b00};

  // Redirect outranks a taken branch, which outranks sequential flow.
  always_comb begin
    nextPc_o = pcPlus4_i;
    if (redirect_i) begin
      nextPc_o = redirectPc_i & 32'hFFFF_FFFC;
    end else if (taken_i) begin
      nextPc_o = branchTarget;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage of the mips core. Owns the program counter, fetches words
//   from instruction memory over a req/ack handshake, holds the fetched word
//   in the instruction register and presents its opcode to the ControlUnit.
//   Ports:
//     clk, rst_n              clock (rising edge), async active-low reset
//     IMemReq/IMemAddr        fetch request and its word-aligned address
//     IMemAck/IMemData        memory response, sampled while IMemReq=1
//     Stall                   downstream cannot take the presented instr
//     Branch, Zero            ControlUnit branch decision and ALU zero flag
//     Redirect/RedirectPC     one-cycle pulse to restart fetch elsewhere
//     Instr/OPCode            instruction register and its opcode field
//     InstrValid              Instr holds a live instruction
//     PCPlus4                 address of Instr + 4
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Instr,
  output logic [5:0]  OPCode,
  output logic        InstrValid,
  output logic [31:0] PCPlus4
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         drop_q;
  logic         imemReq_q;
  logic [31:0]  imemAddr_q;
  logic [31:0]  instr_q;
  logic         instrValid_q;
  logic [31:0]  pcPlus4_q;
  logic [31:0]  nextPc_d;

  // Branch and Zero only influence nextPc_d when no redirect is present,
  // and nextPc_d is only used without a redirect in S_ISSUE, so they are
  // effectively sampled in S_ISSUE alone.
  pc_next u_pc_next (
    .pcPlus4_i    (pcPlus4_q),
    .imm_i        (instr_q[15:0]),
    .taken_i      (Branch & Zero),
    .redirect_i   (Redirect),
    .redirectPc_i (RedirectPC),
    .nextPc_o     (nextPc_d)
  );

  // Fetch sequencing, PC, pending-drop flag and all output registers.
  // A redirect that arrives while a request is outstanding cannot withdraw
  // it, so drop_q remembers to discard exactly one returning word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      imemReq_q    <= 1'b0;
      imemAddr_q   <= RESET_PC;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
      pcPlus4_q    <= RESET_PC + 32'd4;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q   <= S_FETCH;
          imemReq_q <= 1'b1;
          if (Redirect) begin
            pc_q       <= nextPc_d;
            imemAddr_q <= nextPc_d;
          end else begin
            imemAddr_q <= pc_q;
          end
        end

        S_FETCH: begin
          if (IMemAck) begin
            if (drop_q || Redirect) begin
              // The returning word belongs to the abandoned stream; reissue
              // straight away at the newest PC.
              drop_q <= 1'b0;
              if (Redirect) begin
                pc_q       <= nextPc_d;
                imemAddr_q <= nextPc_d;
              end else begin
                imemAddr_q <= pc_q;
              end
            end else begin
              instr_q      <= IMemData;
              pcPlus4_q    <= imemAddr_q + 32'd4;
              instrValid_q <= 1'b1;
              imemReq_q    <= 1'b0;
              state_q      <= S_ISSUE;
            end
          end else if (Redirect) begin
            pc_q   <= nextPc_d;
            drop_q <= 1'b1;
          end
        end

        S_ISSUE: begin
          // A redirect discards the instruction even when stalled.
          if (Redirect || !Stall) begin
            pc_q         <= nextPc_d;
            imemAddr_q   <= nextPc_d;
            imemReq_q    <= 1'b1;
            instrValid_q <= 1'b0;
            state_q      <= S_FETCH;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign IMemReq    = imemReq_q;
  assign IMemAddr   = imemAddr_q;
  assign Instr      = instr_q;
  assign OPCode     = instr_q[31:26];
  assign InstrValid = instrValid_q;
  assign PCPlus4    = pcPlus4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A memory responder answers
//   fetch requests with configurable latency, a driver plays the ControlUnit
//   and downstream consumer, and a reference model predicts the address of
//   every instruction that should be delivered. A monitor compares each
//   delivered instruction against those predictions.
module tb_instruction_fetch;
  import mips_pkg::*;

  localparam logic [31:0] TB_RESET_PC = DEFAULT_RESET_PC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = '0;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic [31:0] Instr;
  logic [5:0]  OPCode;
  logic        InstrValid;
  logic [31:0] PCPlus4;

  instruction_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .Stall      (Stall),
    .Branch     (Branch),
    .Zero       (Zero),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Instr      (Instr),
    .OPCode     (OPCode),
    .InstrValid (InstrValid),
    .PCPlus4    (PCPlus4)
  );

  always #5 clk = ~clk;

  // Instruction memory contents, indexed by word address bits [9:2].
  logic [31:0] mem [256];

  // Scoreboard: addresses of instructions still to be delivered.
  logic [31:0] expQ [$];
  logic [31:0] lastAddr = '0;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Stimulus knobs.
  bit          driveOn = 1'b0;
  int          stallPct = 0;
  int          redirPct = 0;
  int          branchMode = 3;
  int          maxWait = 0;
  int          fixedWait = 0;
  int          spuriousPct = 0;
  bit          forceRedirect = 1'b0;
  logic [31:0] forcedPC = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  // Reference rule: the next instruction follows at +4, or at +4 plus the
  // signed word offset when the branch is taken, all modulo 2^32.
  function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] word,
                                          input bit taken);
    int imm;
    imm = int'($signed(word[15:0]));
    return pc + 32'd4 + (taken ? 32'(imm * 4) : 32'd0);
  endfunction

  function automatic int pickWait();
    return (fixedWait >= 0) ? fixedWait : int'($urandom_range(maxWait));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle of ControlUnit / consumer behaviour, plus the model's view of
  // which instruction the stage must deliver next.
  task automatic applyStimulus();
    bit          st;
    bit          rd;
    bit          br;
    bit          zr;
    logic [31:0] rpc;
    logic [31:0] nxt;
    st  = ($urandom_range(99) < stallPct);
    rd  = forceRedirect || ($urandom_range(99) < redirPct);
    rpc = forceRedirect ? forcedPC : $urandom;
    forceRedirect = 1'b0;
    case (branchMode)
      0:       begin br = $urandom_range(1); zr = $urandom_range(1); end
      1:       begin br = 1'b1; zr = 1'b1; end
      2:       begin br = 1'b1; zr = 1'b0; end
      default: begin br = 1'b0; zr = $urandom_range(1); end
    endcase
    Stall      = st;
    Branch     = br;
    Zero       = zr;
    Redirect   = rd;
    RedirectPC = rpc;
    if (rd) begin
      expQ.delete();
      nxt = rpc & 32'hFFFF_FFFC;
      expQ.push_back(nxt);
      lastAddr = nxt;
    end else if (InstrValid && !st) begin
      nxt = refNext(lastAddr, memWord(lastAddr), br && zr);
      expQ.push_back(nxt);
      lastAddr = nxt;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (driveOn && rst_n) applyStimulus();
    end
  end

  // Memory responder: acks each request after a chosen number of cycles.
  int waitCnt = 0;
  bit reqSeen = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        IMemAck = 1'b0;
        reqSeen = 1'b0;
        waitCnt = pickWait();
      end else begin
        if (IMemAck && reqSeen) waitCnt = pickWait();
        reqSeen = IMemReq;
        if (IMemReq) begin
          if (waitCnt == 0) begin
            IMemAck  = 1'b1;
            IMemData = memWord(IMemAddr);
          end else begin
            IMemAck  = 1'b0;
            IMemData = $urandom;
            waitCnt--;
          end
        end else begin
          IMemAck  = ($urandom_range(99) < spuriousPct);
          IMemData = $urandom;
        end
      end
    end
  end

  // Monitor: pops the expected address when a new instruction appears and
  // checks that a stalled instruction stays put.
  logic [31:0] curExp = '0;
  logic [31:0] curWord = '0;
  bit          prevValid = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prevValid = 1'b0;
      end else begin
        if (InstrValid && !prevValid) begin
          delivered++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedInstr actual=%h required=none", Instr);
          end else begin
            curExp  = expQ.pop_front();
            curWord = memWord(curExp);
            checkOutput("Instr", Instr, curWord);
            checkOutput("PCPlus4", PCPlus4, curExp + 32'd4);
            checkOutput("OPCode", {26'd0, OPCode}, {26'd0, curWord[31:26]});
          end
        end else if (InstrValid && prevValid) begin
          checkOutput("holdInstr", Instr, curWord);
          checkOutput("holdPCPlus4", PCPlus4, curExp + 32'd4);
          checkOutput("holdIMemReq", {31'd0, IMemReq}, 32'd0);
        end
        prevValid = InstrValid;
      end
    end
  end

  task automatic waitDeliveries(input int n, input int budget, input string name);
    int target;
    int cyc;
    target = delivered + n;
    cyc = 0;
    while (delivered < target && cyc < budget) begin
      @(posedge clk);
      #3;
      cyc++;
    end
    checks++;
    if (delivered < target) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, n - (target - delivered), n);
    end
  endtask

  // Asserts reset at once, checks the reset values, releases it and checks
  // the first request. Optionally redirects during the idle cycle.
  task automatic doReset(input bit idleRedir, input logic [31:0] rpc);
    logic [31:0] first;
    driveOn    = 1'b0;
    rst_n      = 1'b0;
    Stall      = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    first = idleRedir ? (rpc & 32'hFFFF_FFFC) : TB_RESET_PC;
    expQ.delete();
    expQ.push_back(first);
    lastAddr = first;
    #1;
    checkOutput("rstIMemReq", {31'd0, IMemReq}, 32'd0);
    checkOutput("rstIMemAddr", IMemAddr, TB_RESET_PC);
    checkOutput("rstInstr", Instr, 32'd0);
    checkOutput("rstOPCode", {26'd0, OPCode}, 32'd0);
    checkOutput("rstInstrValid", {31'd0, InstrValid}, 32'd0);
    checkOutput("rstPCPlus4", PCPlus4, TB_RESET_PC + 32'd4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (idleRedir) begin
      Redirect   = 1'b1;
      RedirectPC = rpc;
    end
    @(posedge clk);
    #3;
    Redirect = 1'b0;
    checkOutput("firstIMemReq", {31'd0, IMemReq}, 32'd1);
    checkOutput("firstIMemAddr", IMemAddr, first);
    driveOn = 1'b1;
  endtask

  task automatic fillLinear();
    for (int i = 0; i < 256; i++) mem[i] = {OP_RTYPE, 10'(i), 16'h0000};
  endtask

  task automatic fillRandom();
    logic [31:0] r;
    logic [5:0]  op;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      case ($urandom_range(3))
        0:       op = OP_RTYPE;
        1:       op = OP_BEQ;
        2:       op = OP_LW;
        default: op = OP_SW;
      endcase
      mem[i] = {op, r[25:0]};
    end
  endtask

  // beq at 0x10 with offset -4 words; every other word has offset 0.
  task automatic runBeq(input int mode, input logic [31:0] expAddr, input string name);
    bit found;
    fillLinear();
    mem[4] = {OP_BEQ, 5'd1, 5'd2, 16'hFFFC};
    fixedWait  = 0;
    stallPct   = 0;
    redirPct   = 0;
    branchMode = mode;
    doReset(1'b0, '0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #3;
      if (InstrValid && PCPlus4 == 32'h14) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({name, "Seen"}, {31'd0, found}, 32'd1);
    @(posedge clk);
    #3;
    checkOutput({name, "Req"}, {31'd0, IMemReq}, 32'd1);
    checkOutput({name, "Addr"}, IMemAddr, expAddr);
    waitDeliveries(3, 40, {name, "Flow"});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int d0;
    int cnt;
    bit found;
    #1;

    // Zero-wait streaming: one instruction every two cycles.
    fillLinear();
    fixedWait = 0;
    branchMode = 3;
    doReset(1'b0, '0);
    waitDeliveries(1, 20, "firstFetch");
    d0 = delivered;
    repeat (20) begin
      @(posedge clk);
      #3;
    end
    checkOutput("throughput", 32'(delivered - d0), 32'd10);

    // Ack delayed by three cycles: request held four cycles.
    fixedWait = 3;
    doReset(1'b0, '0);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #3;
      if (IMemReq && IMemAddr == TB_RESET_PC && !InstrValid) cnt++;
      else break;
    end
    checkOutput("delayReqCycles", 32'(cnt), 32'd4);
    checkOutput("delayValid", {31'd0, InstrValid}, 32'd1);
    waitDeliveries(2, 40, "delayFlow");

    // Taken and not-taken beq.
    runBeq(1, 32'h0000_0004, "beqTaken");
    runBeq(2, 32'h0000_0014, "beqNotTaken");

    // Five stalled cycles with Branch/Zero toggling.
    fillLinear();
    fixedWait = 1;
    branchMode = 0;
    stallPct = 100;
    doReset(1'b0, '0);
    waitDeliveries(1, 20, "stallFirst");
    repeat (5) begin
      @(posedge clk);
      #3;
    end
    checkOutput("stallValid", {31'd0, InstrValid}, 32'd1);
    checkOutput("stallIMemReq", {31'd0, IMemReq}, 32'd0);
    stallPct = 0;
    waitDeliveries(3, 40, "stallRelease");

    // Redirect to 0x100 while 0x20 waits for its ack, then a wrapping one.
    fillLinear();
    fixedWait = 2;
    branchMode = 3;
    doReset(1'b0, '0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #3;
      if (IMemReq && IMemAddr == 32'h20) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach0x20", {31'd0, found}, 32'd1);
    forcedPC = 32'h0000_0100;
    forceRedirect = 1'b1;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #3;
      if (IMemReq && IMemAddr == 32'h20) begin
        cnt++;
        checkOutput("dropNoValid", {31'd0, InstrValid}, 32'd0);
      end else begin
        break;
      end
    end
    checkOutput("redirHoldCycles", 32'(cnt), 32'd3);
    checkOutput("redirIMemAddr", IMemAddr, 32'h0000_0100);
    checkOutput("redirIMemReq", {31'd0, IMemReq}, 32'd1);
    checkOutput("redirNoValid", {31'd0, InstrValid}, 32'd0);
    waitDeliveries(2, 40, "redirFlow");
    forcedPC = 32'hFFFF_FFFF;
    forceRedirect = 1'b1;
    waitDeliveries(3, 60, "wrapFlow");

    // Reset while a request is outstanding; stray acks around it.
    fixedWait = 3;
    spuriousPct = 100;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #3;
      if (IMemReq) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reqBeforeReset", {31'd0, found}, 32'd1);
    doReset(1'b0, '0);
    waitDeliveries(2, 60, "afterMidReset");

    // Randomised run, starting with a redirect in the idle cycle.
    fillRandom();
    fixedWait = -1;
    maxWait = 3;
    stallPct = 30;
    redirPct = 4;
    branchMode = 0;
    spuriousPct = 20;
    doReset(1'b1, 32'h0000_0203);
    d0 = delivered;
    repeat (3000) @(posedge clk);
    #3;
    checks++;
    if (delivered - d0 < 100) begin
      errors++;
      $display("[TB] FAIL randomProgress actual=%0d required>=100", delivered - d0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the mips core: owns the program counter, requests instruction words from instruction memory over a req/ack handshake, holds each fetched word in the instruction register and presents its OPCode field to the ControlUnit. It consumes the ControlUnit's Branch decision, together with the ALU Zero flag, to select the next PC. It therefore drives the ControlUnit's OPCode input and consumes its Branch output.

## Interface

- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IMemReq  out  1  fetch request; held until IMemAck.
- IMemAddr  out  32  word-aligned fetch address; stable while IMemReq=1.
- IMemAck  in  1  memory has IMemData valid this cycle; ignored when IMemReq=0.
- IMemData  in  32  instruction word, sampled when IMemReq & IMemAck.
- Stall  in  1  downstream cannot accept the presented instruction.
- Branch  in  1  from ControlUnit, decoded from the current OPCode.
- Zero  in  1  ALU zero flag for the current instruction.
- Redirect  in  1  one-cycle pulse: abandon the current stream.
- RedirectPC  in  32  new PC when Redirect=1; bits [1:0] ignored (forced 0).
- Instr  out  32  instruction register.
- OPCode  out  6  Instr[31:26], to ControlUnit.
- InstrValid  out  1  Instr holds a live instruction.
- PCPlus4  out  32  address of Instr + 4.

## Operation

- The FSM has three states:
  - S_IDLE: entered on reset, for exactly one cycle; → S_FETCH.
  - S_FETCH: IMemReq=1, IMemAddr=the address latched on entry.
    - On IMemAck with Drop=0: Instr ← IMemData, PCPlus4 ← IMemAddr+4; → S_ISSUE.
    - On IMemAck with Drop=1: discard the data, clear Drop, latch IMemAddr ← PC; stay in S_FETCH with IMemReq still 1.
  - S_ISSUE: InstrValid=1.
    - Stall=1: hold everything.
    - Stall=0: the instruction is consumed; PC ← next PC; → S_FETCH with IMemAddr ← next PC.
- Next PC, in priority order:
  - Redirect: {RedirectPC[31:2],2'b00}.
  - Branch & Zero: PCPlus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00}, modulo 2^32.
  - Otherwise: PCPlus4.
- Branch and Zero are sampled only in S_ISSUE with Stall=0. They are ignored in every other state.
- Redirect in S_ISSUE:
  - The current instruction is discarded even if Stall=1.
  - InstrValid drops next cycle; → S_FETCH at RedirectPC.
- Redirect in S_FETCH:
  - The outstanding request is not withdrawn and IMemAddr does not change.
  - PC ← RedirectPC and Drop ← 1.
  - If IMemAck arrives in the same cycle, the word is dropped.
- Redirect in S_IDLE: PC ← RedirectPC; the first fetch goes to RedirectPC.
- A second Redirect while Drop=1 only overwrites PC. At most one word is ever dropped.
- Address arithmetic is 32-bit unsigned with wrap-around: 32'hFFFF_FFFC + 4 = 0.

## Timing

- Reset values:
  - IMemReq=0, IMemAddr=RESET_PC, Instr=0, OPCode=0, InstrValid=0.
  - PCPlus4=RESET_PC+4, PC=RESET_PC, Drop=0, state=S_IDLE.
- Reset mid-operation (any state, including an outstanding request): all of the above apply immediately, and IMemReq deasserts asynchronously.
- First request: IMemReq=1 in the second cycle after rst_n deasserts.
- Latency: IMemAck at edge N → InstrValid=1 after edge N.
- Zero-wait memory with no stalls sustains one instruction per 2 cycles.
- IMemReq, IMemAddr, Instr, OPCode, InstrValid and PCPlus4 are all registered. None depends combinationally on an input.
- OPCode changes only when Instr loads.

## Structure

- Package mips_pkg holds:
  - opcode constants: OP_RTYPE 6'h00, OP_BEQ 6'h04, OP_LW 6'h23, OP_SW 6'h2B;
  - the fetch state enumeration;
  - the default RESET_PC.
- Sub-module pc_next: combinational next-PC mux and adder. It takes PCPlus4, Instr[15:0], Branch&Zero, Redirect and RedirectPC.
- FSM, PC, Drop and the output registers live in instruction_fetch.

## Test plan

- Reset, zero-wait ack, Stall=0, Branch=0 → IMemAddr sequence 0, 4, 8. InstrValid high every other cycle. OPCode = IMemData[31:26].
- ack delayed 3 cycles → IMemReq held at 1 and IMemAddr stable for 4 cycles. InstrValid rises exactly one cycle after the ack.
- Instr=beq at 0x10 with imm 16'hFFFC, Branch=1, Zero=1 → next IMemAddr = 0x14 + 0xFFFF_FFF0 = 0x04. With Zero=0 → 0x14.
- Stall=1 for 5 cycles in S_ISSUE → Instr, InstrValid, PCPlus4 unchanged, IMemReq=0. With Branch toggling meanwhile, the next address is unaffected.
- Redirect to 0x100 while a fetch of 0x20 waits 2 cycles for ack → IMemAddr stays 0x20 until ack. The word is dropped with InstrValid=0, then IMemAddr=0x100.
- rst_n low while IMemReq=1 → IMemReq=0 immediately. After release the first request is to RESET_PC. An ack arriving after reset is ignored.
